// File: rtl/sprite_tile_rasterizer_if.sv
// Bundles the tile request inputs and the pixel-stream handshake of sprite_tile_rasterizer.
// The slave modport is the rasterizer; master is the requester / pixel consumer side.
interface sprite_tile_rasterizer_if #(
    parameter int TILE    = 16,
    parameter int COORD_W = 10
);
    logic                   start;
    logic [COORD_W-1:0]     origin_x;
    logic [COORD_W-1:0]     origin_y;
    logic                   frame_sel;
    logic [TILE*TILE-1:0]   mask_f1;
    logic [TILE*TILE-1:0]   mask_f2;
    logic [11:0]            fg_rgb;
    logic [11:0]            bg_rgb;
    logic                   transparent;
    logic                   px_valid;
    logic                   px_ready;
    logic [COORD_W-1:0]     px_x;
    logic [COORD_W-1:0]     px_y;
    logic [11:0]            px_rgb;
    logic                   px_opaque;
    logic                   px_last;
    logic                   busy;
    logic                   done;

    modport master (
        output start, origin_x, origin_y, frame_sel, mask_f1, mask_f2,
               fg_rgb, bg_rgb, transparent, px_ready,
        input  px_valid, px_x, px_y, px_rgb, px_opaque, px_last, busy, done
    );

    modport slave (
        input  start, origin_x, origin_y, frame_sel, mask_f1, mask_f2,
               fg_rgb, bg_rgb, transparent, px_ready,
        output px_valid, px_x, px_y, px_rgb, px_opaque, px_last, busy, done
    );
endinterface

// File: rtl/sprite_tile_rasterizer.sv
// Snapshots one animation frame of a sprite mask plus colours, then streams the
// tile row-major as registered pixel beats over a valid/ready handshake.
module sprite_tile_rasterizer #(
    parameter int TILE    = 16,
    parameter int COORD_W = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    sprite_tile_rasterizer_if.slave  bus
);
    localparam int CW   = $clog2(TILE);
    localparam int NPIX = TILE * TILE;
    localparam logic [CW-1:0] MAX_IDX = CW'(TILE - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               state_q;
    logic [NPIX-1:0]      mask_q;
    logic [COORD_W-1:0]   origin_x_q;
    logic [COORD_W-1:0]   origin_y_q;
    logic [11:0]          fg_q;
    logic [11:0]          bg_q;
    logic                 transp_q;
    logic [CW-1:0]        col_q;
    logic [CW-1:0]        row_q;

    logic                 px_valid_q;
    logic [COORD_W-1:0]   px_x_q;
    logic [COORD_W-1:0]   px_y_q;
    logic [11:0]          px_rgb_q;
    logic                 px_opaque_q;
    logic                 px_last_q;
    logic                 busy_q;
    logic                 done_q;

    logic [CW-1:0]        col_d;
    logic [CW-1:0]        row_d;
    logic                 pix_bit_d;
    logic                 last_d;
    logic [NPIX-1:0]      sel_mask;

    // Position of the beat that follows the one currently presented; the mask
    // index is just {row,col} because TILE is a power of two.
    always_comb begin
        col_d     = col_q + 1'b1;
        row_d     = (col_q == MAX_IDX) ? row_q + 1'b1 : row_q;
        pix_bit_d = mask_q[{row_d, col_d}];
        last_d    = (row_d == MAX_IDX) && (col_d == MAX_IDX);
        sel_mask  = bus.frame_sel ? bus.mask_f2 : bus.mask_f1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            origin_x_q  <= '0;
            origin_y_q  <= '0;
            fg_q        <= '0;
            bg_q        <= '0;
            transp_q    <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            px_valid_q  <= 1'b0;
            px_x_q      <= '0;
            px_y_q      <= '0;
            px_rgb_q    <= '0;
            px_opaque_q <= 1'b0;
            px_last_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        mask_q      <= sel_mask;
                        origin_x_q  <= bus.origin_x;
                        origin_y_q  <= bus.origin_y;
                        fg_q        <= bus.fg_rgb;
                        bg_q        <= bus.bg_rgb;
                        transp_q    <= bus.transparent;
                        col_q       <= '0;
                        row_q       <= '0;
                        // Pixel (0,0) is taken straight from the inputs so it
                        // is on the bus in the cycle after accept.
                        px_valid_q  <= 1'b1;
                        px_x_q      <= bus.origin_x;
                        px_y_q      <= bus.origin_y;
                        px_rgb_q    <= sel_mask[0] ? bus.fg_rgb : bus.bg_rgb;
                        px_opaque_q <= sel_mask[0] | ~bus.transparent;
                        px_last_q   <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.px_ready) begin
                        if (px_last_q) begin
                            px_valid_q <= 1'b0;
                            px_last_q  <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= S_DONE;
                        end else begin
                            col_q       <= col_d;
                            row_q       <= row_d;
                            px_x_q      <= origin_x_q + COORD_W'(col_d);
                            px_y_q      <= origin_y_q + COORD_W'(row_d);
                            px_rgb_q    <= pix_bit_d ? fg_q : bg_q;
                            px_opaque_q <= pix_bit_d | ~transp_q;
                            px_last_q   <= last_d;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.px_valid  = px_valid_q;
    assign bus.px_x      = px_x_q;
    assign bus.px_y      = px_y_q;
    assign bus.px_rgb    = px_rgb_q;
    assign bus.px_opaque = px_opaque_q;
    assign bus.px_last   = px_last_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_sprite_tile_rasterizer.sv
// Directed bench for sprite_tile_rasterizer: streams whole tiles and compares every
// beat against coordinates and colours computed from the stimulus.
module tb_sprite_tile_rasterizer;
    localparam int TILE = 16;
    localparam int CW   = 10;
    localparam int NPIX = TILE * TILE;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sprite_tile_rasterizer_if #(.TILE(TILE), .COORD_W(CW)) bus();

    sprite_tile_rasterizer #(.TILE(TILE), .COORD_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [CW-1:0] bx   [NPIX];
    logic [CW-1:0] by   [NPIX];
    logic [11:0]   brgb [NPIX];
    logic          bop  [NPIX];
    logic          blast[NPIX];
    int   n_beats, done_cnt, stall_bad, last_cnt, first_cyc, hs_last_cyc, done_cyc;
    logic busy_after, valid_at_done;

    function automatic logic [NPIX-1:0] rand_mask();
        logic [NPIX-1:0] m;
        for (int i = 0; i < NPIX / 32; i++) m[i*32 +: 32] = $urandom();
        return m;
    endfunction

    // Presents a request at the current negedge; start is sampled on the next posedge.
    task automatic do_start(input logic [CW-1:0] ox, input logic [CW-1:0] oy, input logic fsel,
                            input logic [NPIX-1:0] m1, input logic [NPIX-1:0] m2,
                            input logic [11:0] fg, input logic [11:0] bg, input logic tr);
        bus.origin_x = ox;  bus.origin_y = oy;  bus.frame_sel = fsel;
        bus.mask_f1 = m1;   bus.mask_f2 = m2;   bus.fg_rgb = fg;  bus.bg_rgb = bg;
        bus.transparent = tr;
        bus.start = 1'b1;
        @(posedge clk);
    endtask

    // Records accepted beats; returns at the negedge one cycle after done.
    task automatic collect_tile(input int ready_pct, input int inject_at);
        logic stalled, r, injected, slast, sop;
        logic [CW-1:0] sx, sy;
        logic [11:0] srgb;
        n_beats = 0; done_cnt = 0; stall_bad = 0; last_cnt = 0;
        first_cyc = -1; hs_last_cyc = -1; done_cyc = -1;
        busy_after = 1'b1; valid_at_done = 1'b1;
        stalled = 1'b0; injected = 1'b0;
        sx = '0; sy = '0; srgb = '0; sop = 1'b0; slast = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (inject_at >= 0 && n_beats == inject_at && !injected) begin
                injected = 1'b1;
                bus.start = 1'b1;
                bus.mask_f1 = ~bus.mask_f1;  bus.mask_f2 = ~bus.mask_f2;
                bus.fg_rgb = bus.fg_rgb ^ 12'hFFF;  bus.bg_rgb = bus.bg_rgb ^ 12'h5A5;
                bus.origin_x = bus.origin_x + 10'd7;
                bus.transparent = ~bus.transparent;
            end
            if (bus.done) begin done_cnt++; done_cyc = c; valid_at_done = bus.px_valid; end
            if (done_cyc >= 0 && c == done_cyc + 1) begin busy_after = bus.busy; break; end
            if (stalled) begin
                if (!bus.px_valid || bus.px_x !== sx || bus.px_y !== sy || bus.px_rgb !== srgb ||
                    bus.px_opaque !== sop || bus.px_last !== slast) stall_bad++;
            end
            stalled = 1'b0;
            r = ($urandom_range(0, 99) < ready_pct);
            bus.px_ready = r;
            if (bus.px_valid) begin
                if (first_cyc < 0) first_cyc = c;
                if (r) begin
                    if (n_beats < NPIX) begin
                        bx[n_beats] = bus.px_x;  by[n_beats] = bus.px_y;
                        brgb[n_beats] = bus.px_rgb;  bop[n_beats] = bus.px_opaque;
                        blast[n_beats] = bus.px_last;
                    end
                    if (bus.px_last) begin last_cnt++; hs_last_cyc = c; end
                    n_beats++;
                end else begin
                    stalled = 1'b1;
                    sx = bus.px_x; sy = bus.px_y; srgb = bus.px_rgb; sop = bus.px_opaque; slast = bus.px_last;
                end
            end
        end
    endtask

    // Counts beats whose coordinates, colour or opacity differ from the snapshot.
    function automatic int pixel_errors(input logic [CW-1:0] ox, input logic [CW-1:0] oy,
                                        input logic [NPIX-1:0] m, input logic [11:0] fg,
                                        input logic [11:0] bg, input logic tr);
        int bad;
        logic b;
        logic [CW-1:0] ex, ey;
        bad = 0;
        for (int i = 0; i < NPIX; i++) begin
            b  = m[i];
            ex = ox + CW'(i % TILE);
            ey = oy + CW'(i / TILE);
            if (bx[i] !== ex || by[i] !== ey) bad++;
            if (brgb[i] !== (b ? fg : bg)) bad++;
            if (bop[i] !== (b | ~tr)) bad++;
            if (blast[i] !== (i == NPIX - 1)) bad++;
        end
        return bad;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.px_ready = 1'b0; bus.origin_x = '0; bus.origin_y = '0;
        bus.frame_sel = 1'b0; bus.mask_f1 = '0; bus.mask_f2 = '0;
        bus.fg_rgb = '0; bus.bg_rgb = '0; bus.transparent = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.px_valid, bus.px_x, bus.px_y, bus.px_rgb, bus.px_opaque, bus.px_last, bus.busy, bus.done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b x=%0d y=%0d rgb=%h op=%b last=%b busy=%b done=%b, required all 0",
                     bus.px_valid, bus.px_x, bus.px_y, bus.px_rgb, bus.px_opaque, bus.px_last, bus.busy, bus.done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: valid=%b busy=%b", bus.px_valid, bus.busy);
    endtask

    task automatic test_basic();
        int bad;
        do_start(10'd100, 10'd50, 1'b0, 256'h1, 256'h0, 12'hFF0, 12'h000, 1'b0);
        collect_tile(100, -1);
        $display("basic: beats=%0d first=(%0d,%0d) rgb=%h last=(%0d,%0d) done_cnt=%0d",
                 n_beats, bx[0], by[0], brgb[0], bx[NPIX-1], by[NPIX-1], done_cnt);
        checks++; if (n_beats != NPIX) begin errors++; $display("FAIL basic_beats: got %0d required 256", n_beats); end
        checks++; if (first_cyc != 0) begin errors++; $display("FAIL basic_latency: first valid at +%0d required +0", first_cyc); end
        checks++; if (bx[0] !== 10'd100 || by[0] !== 10'd50 || brgb[0] !== 12'hFF0)
            begin errors++; $display("FAIL basic_first: (%0d,%0d) rgb %h required (100,50) rgb ff0", bx[0], by[0], brgb[0]); end
        checks++; if (bx[NPIX-1] !== 10'd115 || by[NPIX-1] !== 10'd65 || blast[NPIX-1] !== 1'b1)
            begin errors++; $display("FAIL basic_lastbeat: (%0d,%0d) last=%b required (115,65) last=1", bx[NPIX-1], by[NPIX-1], blast[NPIX-1]); end
        bad = pixel_errors(10'd100, 10'd50, 256'h1, 12'hFF0, 12'h000, 1'b0);
        checks++; if (bad != 0) begin errors++; $display("FAIL basic_pixels: %0d mismatches required 0", bad); end
        checks++; if (hs_last_cyc != NPIX - 1) begin errors++; $display("FAIL basic_consecutive: last handshake at +%0d required +255", hs_last_cyc); end
        checks++; if (done_cnt != 1 || done_cyc != hs_last_cyc + 1 || valid_at_done !== 1'b0)
            begin errors++; $display("FAIL basic_done: cnt=%0d at +%0d valid=%b required 1 at +%0d valid=0", done_cnt, done_cyc, valid_at_done, hs_last_cyc + 1); end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b required 0", busy_after); end
    endtask

    task automatic test_back_to_back();
        logic [NPIX-1:0] cb;
        int bad;
        for (int i = 0; i < NPIX; i++) cb[i] = ((i % TILE) + (i / TILE)) % 2 == 1;
        do_start(10'd0, 10'd0, 1'b1, 256'h0, cb, 12'h0F0, 12'hA05, 1'b1);
        collect_tile(100, -1);
        $display("back_to_back: beats=%0d first=+%0d op0=%b op1=%b rgb1=%h", n_beats, first_cyc, bop[0], bop[1], brgb[1]);
        checks++; if (first_cyc != 0) begin errors++; $display("FAIL b2b_latency: first valid at +%0d required +0", first_cyc); end
        checks++; if (n_beats != NPIX) begin errors++; $display("FAIL b2b_beats: got %0d required 256", n_beats); end
        checks++; if (bop[0] !== 1'b0 || bop[1] !== 1'b1 || brgb[1] !== 12'h0F0)
            begin errors++; $display("FAIL b2b_checker_head: op0=%b op1=%b rgb1=%h required 0 1 0f0", bop[0], bop[1], brgb[1]); end
        bad = pixel_errors(10'd0, 10'd0, cb, 12'h0F0, 12'hA05, 1'b1);
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_pixels: %0d mismatches required 0", bad); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL b2b_done: got %0d required 1", done_cnt); end
    endtask

    task automatic test_random_ready();
        logic [NPIX-1:0] m;
        int bad;
        m = rand_mask();
        do_start(10'd200, 10'd300, 1'b0, m, ~m, 12'h123, 12'hCDE, 1'b1);
        collect_tile(50, -1);
        $display("random_ready: beats=%0d stall_bad=%0d last_cnt=%0d done_cnt=%0d", n_beats, stall_bad, last_cnt, done_cnt);
        checks++; if (n_beats != NPIX) begin errors++; $display("FAIL rr_beats: got %0d required 256", n_beats); end
        checks++; if (stall_bad != 0) begin errors++; $display("FAIL rr_stall_stable: %0d unstable stalls required 0", stall_bad); end
        bad = pixel_errors(10'd200, 10'd300, m, 12'h123, 12'hCDE, 1'b1);
        checks++; if (bad != 0) begin errors++; $display("FAIL rr_pixels: %0d mismatches required 0", bad); end
        checks++; if (last_cnt != 1 || done_cnt != 1)
            begin errors++; $display("FAIL rr_last_done: last=%0d done=%0d required 1 1", last_cnt, done_cnt); end
    endtask

    task automatic test_wrap();
        int bad;
        do_start(10'd1020, 10'd1020, 1'b0, 256'h0, 256'h0, 12'h111, 12'h222, 1'b0);
        collect_tile(100, -1);
        $display("wrap: x3=%0d x4=%0d x15=%0d y(row4)=%0d", bx[3], bx[4], bx[15], by[64]);
        checks++; if (bx[3] !== 10'd1023 || bx[4] !== 10'd0 || bx[15] !== 10'd11)
            begin errors++; $display("FAIL wrap_x: %0d %0d %0d required 1023 0 11", bx[3], bx[4], bx[15]); end
        checks++; if (by[48] !== 10'd1023 || by[64] !== 10'd0 || by[NPIX-1] !== 10'd11)
            begin errors++; $display("FAIL wrap_y: %0d %0d %0d required 1023 0 11", by[48], by[64], by[NPIX-1]); end
        bad = pixel_errors(10'd1020, 10'd1020, 256'h0, 12'h111, 12'h222, 1'b0);
        checks++; if (bad != 0) begin errors++; $display("FAIL wrap_pixels: %0d mismatches required 0", bad); end
    endtask

    task automatic test_mid_run_start();
        logic [NPIX-1:0] m;
        int bad, extra;
        m = rand_mask();
        do_start(10'd40, 10'd60, 1'b1, ~m, m, 12'h9AB, 12'h345, 1'b0);
        collect_tile(70, 100);
        extra = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.px_valid || bus.busy || bus.done) extra++;
        end
        $display("mid_run_start: beats=%0d done_cnt=%0d idle_violations=%0d", n_beats, done_cnt, extra);
        checks++; if (n_beats != NPIX) begin errors++; $display("FAIL mid_beats: got %0d required 256", n_beats); end
        bad = pixel_errors(10'd40, 10'd60, m, 12'h9AB, 12'h345, 1'b0);
        checks++; if (bad != 0) begin errors++; $display("FAIL mid_snapshot: %0d mismatches required 0", bad); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL mid_done: got %0d required 1", done_cnt); end
        checks++; if (extra != 0) begin errors++; $display("FAIL mid_not_queued: %0d active cycles after done required 0", extra); end
    endtask

    task automatic test_reset_mid_run();
        int seen, spurious;
        logic [NPIX-1:0] m;
        int bad;
        do_start(10'd500, 10'd600, 1'b0, 256'hFFFF, 256'h0, 12'hF00, 12'h00F, 1'b0);
        seen = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.px_ready = 1'b1;
            if (bus.px_valid) seen++;
            if (seen == 38) break;
        end
        checks++; if (seen != 38 || bus.px_x !== 10'd505 || bus.px_y !== 10'd602)
            begin errors++; $display("FAIL rst_beat37: seen=%0d at (%0d,%0d) required 38 at (505,602)", seen, bus.px_x, bus.px_y); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.px_valid !== 1'b0 || bus.busy !== 1'b0 || bus.px_x !== 10'd0)
            begin errors++; $display("FAIL rst_immediate: valid=%b busy=%b x=%0d required 0 0 0", bus.px_valid, bus.busy, bus.px_x); end
        spurious = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.done || bus.px_valid) spurious++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (bus.done || bus.px_valid) spurious++;
        end
        checks++; if (spurious != 0) begin errors++; $display("FAIL rst_no_done: %0d spurious cycles required 0", spurious); end
        m = rand_mask();
        do_start(10'd3, 10'd4, 1'b0, m, 256'h0, 12'h777, 12'h888, 1'b1);
        collect_tile(100, -1);
        $display("reset_mid_run: restart first=(%0d,%0d) beats=%0d done_cnt=%0d", bx[0], by[0], n_beats, done_cnt);
        checks++; if (first_cyc != 0 || bx[0] !== 10'd3 || by[0] !== 10'd4)
            begin errors++; $display("FAIL rst_restart_first: +%0d (%0d,%0d) required +0 (3,4)", first_cyc, bx[0], by[0]); end
        bad = pixel_errors(10'd3, 10'd4, m, 12'h777, 12'h888, 1'b1);
        checks++; if (n_beats != NPIX || bad != 0 || done_cnt != 1)
            begin errors++; $display("FAIL rst_restart_tile: beats=%0d mismatches=%0d done=%0d required 256 0 1", n_beats, bad, done_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_random_ready();
        test_wrap();
        test_mid_run_start();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sprite_tile_rasterizer.md
# sprite_tile_rasterizer

Consumes packed sprite masks and produces a scan-ordered pixel stream for one tile. On a start pulse it snapshots one animation frame of a `TILE*TILE` mask plus foreground and background colours. It then emits every pixel of the tile, row-major, over a valid/ready handshake, with screen coordinates and 4-bit-per-channel RGB. It sits between the image/mask store and the frame compositor / VGA line writer.

## Interface
- `TILE`, 16: tile edge in pixels; masks are `TILE*TILE` bits.
- `COORD_W`, 10: screen coordinate width.
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a tile; accepted only when `busy`=0.
- `origin_x`, `origin_y`  in  COORD_W  screen position of tile top-left; latched at accept.
- `frame_sel`  in  1  0 selects `mask_f1`, 1 selects `mask_f2`; latched at accept.
- `mask_f1`, `mask_f2`  in  TILE*TILE  packed masks; bit `row*TILE+col` = pixel (col,row).
- `fg_rgb`, `bg_rgb`  in  12  {r[3:0],g[3:0],b[3:0]}; latched at accept.
- `transparent`  in  1  latched at accept; 1 marks mask-0 pixels non-opaque.
- `px_valid`  out  1  pixel beat available.
- `px_ready`  in  1  downstream accepts beat.
- `px_x`, `px_y`  out  COORD_W  screen coordinates of the beat.
- `px_rgb`  out  12  pixel colour.
- `px_opaque`  out  1  0 only for mask-0 pixels when `transparent`=1.
- `px_last`  out  1  high on beat (TILE-1,TILE-1).
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse after last beat accepted.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: when `start`=1, snapshot the selected mask into an internal `TILE*TILE` register. Latch origin, colours and `transparent`. Clear col/row to 0 and go to RUN.
- RUN: the beat for the current (col,row) is presented.
  - `px_x = origin_x + col`, `px_y = origin_y + row`, both truncated modulo 2^COORD_W (wrap, no saturation).
  - `px_rgb = mask bit ? fg_rgb : bg_rgb`.
  - `px_opaque = mask bit | ~transparent`.
- Handshake is `px_valid & px_ready`. On a handshake, col increments. At col=TILE-1, col wraps to 0 and row increments.
- On a handshake with `px_last`=1, go to DONE.
- DONE: `done`=1 for exactly one cycle, `px_valid`=0, then IDLE.
- `start` in RUN or DONE is ignored and not queued.
- Input masks and colours may change freely after accept; the emitted tile reflects only the snapshot.
- Counters are `$clog2(TILE)` bits. TILE must be a power of two ≥2.

## Timing
- All outputs are registered. Reset values: `px_valid`=0, `px_x`=0, `px_y`=0, `px_rgb`=0, `px_opaque`=0, `px_last`=0, `busy`=0, `done`=0. The snapshot register clears to 0.
- Latency: `start` sampled in cycle N means `px_valid`=1 with pixel (0,0) in cycle N+1, and `busy`=1 from N+1.
- While `px_valid`=1 and `px_ready`=0, all `px_*` outputs hold stable; the beat is never dropped or skipped.
- After a handshake in cycle K, the next pixel is presented in cycle K+1. With `px_ready` held 1, the stream is exactly TILE*TILE consecutive beats.
- The final handshake in cycle L gives `done`=1 and `px_valid`=0 in L+1. `busy`=0 and IDLE hold in L+2.
  - The earliest new `start` is sampled in L+2; its first beat appears in L+3.
- Minimum tile time: TILE*TILE+2 cycles from accept to next accept.
- Asynchronous reset mid-RUN: outputs go to reset values immediately and the state returns to IDLE. There is no partial `done`, and the stream is abandoned.
- `px_ready` may be asserted when `px_valid`=0; this has no effect.

## Test plan
- Reset, then start with TILE=16, origin (100,50), frame_sel=0, mask_f1 = bit 0 only, fg=12'hFF0, bg=12'h000, transparent=0, `px_ready`=1. Required: 256 consecutive beats; first beat (100,50) rgb FF0; the rest rgb 000; last beat (115,65) with `px_last`; `done` 1 cycle later.
- frame_sel=1, mask_f2 = checkerboard, transparent=1. Required: `px_opaque` = mask bit for each pixel; rgb follows fg/bg exactly.
- Random `px_ready` (~50%) across a full tile. Required: outputs stable during every stall; exactly 256 handshakes in row-major order, no duplicates.
- origin (1020,1020) with COORD_W=10. Required: `px_x` runs 1020..1023 then wraps 0..11; `px_y` wraps identically.
- Change masks/colours and pulse `start` mid-RUN. Required: emitted pixels unchanged from the snapshot; second start ignored; exactly one `done`.
- Assert `rst_n`=0 at beat 37. Required: `px_valid`/`busy` drop immediately and no `done`. A new start after release begins at pixel (0,0).
